// File: rtl/pdp_core_ingress.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// pdp_core_ingress
//
// Input stage of the PDP core. Per layer it selects the pooling input source:
// off-fly data from the PDP read DMA, which already carries position sideband,
// or on-fly data from SDP, which carries none. On-fly beats get their sideband
// generated from cube-size counters. Off-fly beats pass unchanged, but their
// sideband is checked against the same counters. The unified 22-bit stream
// leaves through a registered 2-entry skid buffer. A done pulse marks the
// cube_end beat being taken downstream.
//
// Ports
//   nvdla_core_clk, nvdla_core_rstn   clock, async active-low reset
//   reg2dp_op_en                      layer enable; a rising edge arms the block
//   reg2dp_flying_mode                0 = on-fly (SDP), 1 = off-fly (RDMA)
//   reg2dp_cube_in_width/height/channel  cube sizes, each minus 1 (13b)
//   pdp_rdma2dp_valid/ready/pd        off-fly source, 22b pd with sideband
//   sdp2pdp_valid/ready/pd            on-fly source, 8b data only
//   pre2cal_valid/ready/pd            unified 22b output stream
//   ingress_done                      1-cycle pulse on cube_end output accept
//   ingress_err                       sticky off-fly sideband mismatch flag
//
// pd format: [7:0] data, [11:8] pos_c, [12] line_end, [13] surf_end,
//            [14] split_end, [15] cube_end, [21:16] reserved 0
// -----------------------------------------------------------------------------
module pdp_core_ingress (
  input  logic        nvdla_core_clk,
  input  logic        nvdla_core_rstn,
  input  logic        reg2dp_op_en,
  input  logic        reg2dp_flying_mode,
  input  logic [12:0] reg2dp_cube_in_width,
  input  logic [12:0] reg2dp_cube_in_height,
  input  logic [12:0] reg2dp_cube_in_channel,
  input  logic        pdp_rdma2dp_valid,
  output logic        pdp_rdma2dp_ready,
  input  logic [21:0] pdp_rdma2dp_pd,
  input  logic        sdp2pdp_valid,
  output logic        sdp2pdp_ready,
  input  logic [7:0]  sdp2pdp_pd,
  output logic        pre2cal_valid,
  input  logic        pre2cal_ready,
  output logic [21:0] pre2cal_pd,
  output logic        ingress_done,
  output logic        ingress_err
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic        op_en_q;
  logic        mode_q, mode_d;
  logic [12:0] width_q, width_d;
  logic [12:0] height_q, height_d;
  logic [12:0] chan_q, chan_d;
  logic [12:0] w_q, w_d;
  logic [12:0] h_q, h_d;
  logic [12:0] s_q, s_d;
  logic [1:0]  occ_q, occ_d;
  logic [21:0] main_q, main_d;
  logic [21:0] skid_q, skid_d;
  logic        mismatch_q, mismatch_d;
  logic        err_q, err_d;

  logic        arm;
  logic        in_ready;
  logic        in_valid;
  logic        push;
  logic        pop;
  logic        line_end;
  logic        surf_end;
  logic        cube_end;
  logic [7:0]  gen_sb;
  logic [21:0] in_pd;

  // An op_en rising edge only counts while idle; edges mid-layer are ignored.
  assign arm = (state_q == IDLE) && reg2dp_op_en && !op_en_q;

  // Input ready looks only at registered occupancy, never at pre2cal_ready,
  // so there is no combinational path from downstream back to the sources.
  assign in_ready          = (state_q == RUN) && (occ_q != 2'd2);
  assign pdp_rdma2dp_ready = in_ready && mode_q;
  assign sdp2pdp_ready     = in_ready && !mode_q;

  assign in_valid = mode_q ? pdp_rdma2dp_valid : sdp2pdp_valid;
  assign push     = in_valid && in_ready;

  // Sideband for the beat at the current counter position.
  assign line_end = (w_q == width_q);
  assign surf_end = line_end && (h_q == height_q);
  assign cube_end = surf_end && (s_q == chan_q);
  assign gen_sb   = {cube_end, cube_end, surf_end, line_end, s_q[3:0]};

  assign in_pd = mode_q ? pdp_rdma2dp_pd : {6'd0, gen_sb, sdp2pdp_pd};

  // Output always comes from the head register of the skid buffer.
  assign pre2cal_valid = (occ_q != 2'd0);
  assign pre2cal_pd    = main_q;
  assign pop           = pre2cal_valid && pre2cal_ready;

  assign ingress_done = (state_q == DRAIN) && pop && main_q[15];
  assign ingress_err  = err_q;

  // NOTE: every signal assigned in an always_comb gets its default first, so
  // no path through the block leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d  = state_q;
    mode_d   = mode_q;
    width_d  = width_q;
    height_d = height_q;
    chan_d   = chan_q;
    w_d      = w_q;
    h_d      = h_q;
    s_d      = s_q;

    unique case (state_q)
      IDLE:    if (arm) state_d = RUN;
      RUN:     if (push && in_pd[15]) state_d = DRAIN;
      DRAIN:   if (ingress_done) state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (arm) begin
      mode_d   = reg2dp_flying_mode;
      width_d  = reg2dp_cube_in_width;
      height_d = reg2dp_cube_in_height;
      chan_d   = reg2dp_cube_in_channel;
      w_d      = 13'd0;
      h_d      = 13'd0;
      s_d      = 13'd0;
    end else if (push) begin
      // w is innermost, then h, then s.
      if (line_end) begin
        w_d = 13'd0;
        if (h_q == height_q) begin
          h_d = 13'd0;
          s_d = s_q + 13'd1;
        end else begin
          h_d = h_q + 13'd1;
        end
      end else begin
        w_d = w_q + 13'd1;
      end
    end
  end

  // Skid buffer: main holds the head, skid holds the second entry. Push+pop
  // at occupancy 2 cannot happen because ready was 0 there.
  always_comb begin
    occ_d  = occ_q;
    main_d = main_q;
    skid_d = skid_q;
    unique case ({push, pop})
      2'b10: begin
        if (occ_q == 2'd0) begin
          main_d = in_pd;
          occ_d  = 2'd1;
        end else begin
          skid_d = in_pd;
          occ_d  = 2'd2;
        end
      end
      2'b01: begin
        if (occ_q == 2'd2) begin
          main_d = skid_q;
          occ_d  = 2'd1;
        end else begin
          occ_d  = 2'd0;
        end
      end
      2'b11: main_d = in_pd;
      default: ;
    endcase
  end

  // Mismatch is registered once before it reaches the sticky flag.
  always_comb begin
    mismatch_d = push && mode_q && (pdp_rdma2dp_pd[15:8] != gen_sb);
    err_d      = err_q || mismatch_q;
    if (arm) begin
      mismatch_d = 1'b0;
      err_d      = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge value of every other register.
  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      state_q    <= IDLE;
      op_en_q    <= 1'b0;
      mode_q     <= 1'b0;
      width_q    <= 13'd0;
      height_q   <= 13'd0;
      chan_q     <= 13'd0;
      w_q        <= 13'd0;
      h_q        <= 13'd0;
      s_q        <= 13'd0;
      occ_q      <= 2'd0;
      main_q     <= 22'd0;
      mismatch_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_en_q    <= reg2dp_op_en;
      mode_q     <= mode_d;
      width_q    <= width_d;
      height_q   <= height_d;
      chan_q     <= chan_d;
      w_q        <= w_d;
      h_q        <= h_d;
      s_q        <= s_d;
      occ_q      <= occ_d;
      main_q     <= main_d;
      mismatch_q <= mismatch_d;
      err_q      <= err_d;
    end
  end

  // NOTE: the second buffer entry is data only; occupancy says whether it is
  // live, so it needs no reset and a reset flush is just occ_q going to 0.
  always_ff @(posedge nvdla_core_clk) begin
    skid_q <= skid_d;
  end

endmodule

// File: tb/tb_pdp_core_ingress.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_pdp_core_ingress
//
// Drives layers of randomized beats into pdp_core_ingress and checks every
// cycle against a behavioural model. The model derives each beat's sideband
// from its index in the cube with div/mod arithmetic and keeps the in-flight
// beats in a queue. Literal expectations pin the sideband of small cubes.
// -----------------------------------------------------------------------------
module tb_pdp_core_ingress;

  logic        clk;
  logic        rst_n;
  logic        op_en;
  logic        mode;
  logic [12:0] width, height, chan;
  logic        rdma_valid, rdma_ready;
  logic [21:0] rdma_pd;
  logic        sdp_valid, sdp_ready;
  logic [7:0]  sdp_pd;
  logic        pre_valid, pre_ready;
  logic [21:0] pre_pd;
  logic        ingress_done, ingress_err;

  pdp_core_ingress dut (
    .nvdla_core_clk        (clk),
    .nvdla_core_rstn       (rst_n),
    .reg2dp_op_en          (op_en),
    .reg2dp_flying_mode    (mode),
    .reg2dp_cube_in_width  (width),
    .reg2dp_cube_in_height (height),
    .reg2dp_cube_in_channel(chan),
    .pdp_rdma2dp_valid     (rdma_valid),
    .pdp_rdma2dp_ready     (rdma_ready),
    .pdp_rdma2dp_pd        (rdma_pd),
    .sdp2pdp_valid         (sdp_valid),
    .sdp2pdp_ready         (sdp_ready),
    .sdp2pdp_pd            (sdp_pd),
    .pre2cal_valid         (pre_valid),
    .pre2cal_ready         (pre_ready),
    .pre2cal_pd            (pre_pd),
    .ingress_done          (ingress_done),
    .ingress_err           (ingress_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef enum {P_IDLE, P_RUN, P_DRAIN} phase_e;

  phase_e      phase = P_IDLE;
  logic        cfg_mode = 1'b0;
  int          cfg_w = 0, cfg_h = 0, cfg_c = 0;
  logic [21:0] q[$];
  logic [21:0] got_log[$];
  int          mk = 0;
  int          done_cnt = 0;
  logic        err_model = 1'b0;
  logic        mm_d1 = 1'b0;
  logic        op_prev = 1'b0;
  logic        prev_v = 1'b0, prev_r = 1'b0;
  logic [21:0] prev_pd = '0;

  // Sideband of beat k of the current cube: {cube, split, surf, line, pos_c}.
  function automatic logic [7:0] sb_of(input int k);
    int ww, hh, ss;
    logic ln, sf, cb;
    logic [3:0] pc;
    ww = k % (cfg_w + 1);
    hh = (k / (cfg_w + 1)) % (cfg_h + 1);
    ss = k / ((cfg_w + 1) * (cfg_h + 1));
    ln = (ww == cfg_w);
    sf = ln && (hh == cfg_h);
    cb = sf && (ss == cfg_c);
    pc = ss[3:0];
    return {cb, cb, sf, ln, pc};
  endfunction

  always @(negedge clk) begin : monitor
    logic sel_v, sel_r, uns_r, in_acc, out_acc, exp_done;
    logic [21:0] exp_pd, head;
    logic [7:0]  sb;
    if (!rst_n) begin
      q.delete();
      phase     = P_IDLE;
      err_model = 1'b0;
      mm_d1     = 1'b0;
      op_prev   = 1'b0;
      prev_v    = 1'b0;
    end else begin
      sel_v = cfg_mode ? rdma_valid : sdp_valid;
      sel_r = cfg_mode ? rdma_ready : sdp_ready;
      uns_r = cfg_mode ? sdp_ready : rdma_ready;
      head  = (q.size() != 0) ? q[0] : '0;
      check("src_ready", {31'd0, sel_r}, {31'd0, (phase == P_RUN) && (q.size() < 2)});
      check("unsel_ready", {31'd0, uns_r}, 32'd0);
      check("out_valid", {31'd0, pre_valid}, {31'd0, q.size() != 0});
      if (q.size() != 0) check("out_pd", {10'd0, pre_pd}, {10'd0, head});
      if (prev_v && !prev_r) check("pd_stable", {10'd0, pre_pd}, {10'd0, prev_pd});
      in_acc   = sel_v && sel_r;
      out_acc  = pre_valid && pre_ready;
      exp_done = out_acc && (q.size() != 0) && head[15];
      check("done", {31'd0, ingress_done}, {31'd0, exp_done});
      check("err", {31'd0, ingress_err}, {31'd0, err_model});
      if (ingress_done) done_cnt++;

      err_model = err_model | mm_d1;
      mm_d1     = 1'b0;
      if (out_acc) begin
        got_log.push_back(pre_pd);
        if (q.size() != 0) begin
          if (head[15]) phase = P_IDLE;
          void'(q.pop_front());
        end
      end
      if (in_acc) begin
        sb = sb_of(mk);
        if (cfg_mode) begin
          exp_pd = rdma_pd;
          mm_d1  = (rdma_pd[15:8] != sb);
        end else begin
          exp_pd = {6'd0, sb, sdp_pd};
        end
        q.push_back(exp_pd);
        if (exp_pd[15]) phase = P_DRAIN;
        mk++;
      end
      if (op_en && !op_prev && phase == P_IDLE) begin
        phase     = P_RUN;
        mk        = 0;
        err_model = 1'b0;
        mm_d1     = 1'b0;
      end
      op_prev = op_en;
      prev_v  = pre_valid;
      prev_r  = pre_ready;
      prev_pd = pre_pd;
    end
  end

  // ---------------- stimulus ----------------
  task automatic setup_layer(input bit m, input int w, input int h, input int c);
    cfg_mode = m;
    cfg_w    = w;
    cfg_h    = h;
    cfg_c    = c;
    mode     = m;
    width    = 13'(w);
    height   = 13'(h);
    chan     = 13'(c);
    done_cnt = 0;
    got_log.delete();
    @(posedge clk); #1 op_en = 1'b1;
    @(posedge clk); #1 op_en = 1'b0;
    check("err_clear_at_arm", {31'd0, ingress_err}, 32'd0);
  endtask

  task automatic run_layer(input bit m, input int w, input int h, input int c,
                           input bit rnd_rdy, input bit full_valid,
                           input int corrupt, input int bp_at);
    int total, k, cyc, bp_left;
    bit acc, v;
    logic [7:0] data, sb;
    setup_layer(m, w, h, c);
    total   = (w + 1) * (h + 1) * (c + 1);
    bp_left = (bp_at >= 0) ? 5 : 0;
    k   = 0;
    cyc = 0;
    while ((k < total || done_cnt == 0) && cyc < 2000) begin
      v    = (k < total) && (full_valid || $urandom_range(3) != 0);
      data = 8'($urandom);
      sb   = sb_of(k);
      if (k == corrupt) sb[4] = 1'b1;
      if (m) begin
        rdma_valid = v;
        rdma_pd    = {6'd0, sb, data};
        sdp_valid  = 1'b1;
        sdp_pd     = 8'($urandom);
      end else begin
        sdp_valid  = v;
        sdp_pd     = data;
        rdma_valid = 1'b1;
        rdma_pd    = 22'($urandom);
      end
      if (bp_left > 0 && bp_at >= 0 && k >= bp_at) begin
        pre_ready = 1'b0;
        bp_left--;
        if (bp_left == 0) begin
          // Four stalled edges have passed: buffer must be full and holding.
          check("bp_src_ready_low", {31'd0, m ? rdma_ready : sdp_ready}, 32'd0);
          check("bp_out_valid", {31'd0, pre_valid}, 32'd1);
        end
      end else begin
        pre_ready = rnd_rdy ? 1'($urandom_range(1)) : 1'b1;
      end
      @(negedge clk);
      acc = m ? (rdma_valid && rdma_ready) : (sdp_valid && sdp_ready);
      @(posedge clk); #1;
      if (acc) k++;
      cyc++;
    end
    rdma_valid = 1'b0;
    sdp_valid  = 1'b0;
    pre_ready  = 1'b1;
    check("layer_timeout", {31'd0, cyc < 2000}, 32'd1);
    check("done_count", done_cnt, 32'd1);
    check("beats_out", got_log.size(), total);
    @(negedge clk);
    check("idle_after_done", {31'd0, sdp_ready | rdma_ready}, 32'd0);
  endtask

  logic [7:0] exp_sb1 [4];
  int fill_cyc;

  initial begin
    rst_n      = 1'b0;
    op_en      = 1'b0;
    mode       = 1'b0;
    width      = '0;
    height     = '0;
    chan       = '0;
    rdma_valid = 1'b0;
    rdma_pd    = '0;
    sdp_valid  = 1'b0;
    sdp_pd     = '0;
    pre_ready  = 1'b1;
    exp_sb1[0] = 8'h00;
    exp_sb1[1] = 8'h30;
    exp_sb1[2] = 8'h01;
    exp_sb1[3] = 8'hF1;

    #12;
    check("rst_valid", {31'd0, pre_valid}, 32'd0);
    check("rst_pd", {10'd0, pre_pd}, 32'd0);
    check("rst_readys", {30'd0, rdma_ready, sdp_ready}, 32'd0);
    check("rst_done_err", {30'd0, ingress_done, ingress_err}, 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;

    // On-fly 2x1x2 cube, ready tied high.
    run_layer(1'b0, 1, 0, 1, 1'b0, 1'b1, -1, -1);
    for (int i = 0; i < 4 && i < got_log.size(); i++)
      check($sformatf("onfly_sb%0d", i), {24'd0, got_log[i][15:8]}, {24'd0, exp_sb1[i]});

    // Off-fly 3x2x1 with correct sideband, random downstream ready.
    run_layer(1'b1, 2, 1, 0, 1'b1, 1'b0, -1, -1);
    check("offfly_err_clean", {31'd0, ingress_err}, 32'd0);

    // Off-fly 4x2x1 with beat 2 line_end forced to 1.
    run_layer(1'b1, 3, 1, 0, 1'b1, 1'b0, 2, -1);
    check("offfly_err_sticky", {31'd0, ingress_err}, 32'd1);

    // Backpressure for 5 cycles mid-stream; arming also clears the error.
    run_layer(1'b0, 3, 2, 1, 1'b0, 1'b1, -1, 3);

    // A few random layers in both modes.
    for (int i = 0; i < 4; i++)
      run_layer(1'($urandom_range(1)), $urandom_range(3), $urandom_range(2),
                $urandom_range(2), 1'b1, 1'b0, -1, -1);

    // Reset while running with two beats buffered.
    setup_layer(1'b0, 3, 1, 1);
    pre_ready = 1'b0;
    sdp_valid = 1'b1;
    fill_cyc  = 0;
    while (q.size() < 2 && fill_cyc < 20) begin
      sdp_pd = 8'($urandom);
      @(negedge clk);
      fill_cyc++;
    end
    check("fill_timeout", {31'd0, fill_cyc < 20}, 32'd1);
    @(posedge clk); #1 rst_n = 1'b0;
    #1;
    check("midrst_valid", {31'd0, pre_valid}, 32'd0);
    check("midrst_ready", {31'd0, sdp_ready}, 32'd0);
    check("midrst_done", {31'd0, ingress_done}, 32'd0);
    sdp_valid = 1'b0;
    pre_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    check("midrst_no_done", done_cnt, 32'd0);

    // Single-element cube: one beat with every end bit set.
    run_layer(1'b0, 0, 0, 0, 1'b0, 1'b1, -1, -1);
    if (got_log.size() != 0)
      check("unit_cube_sb", {24'd0, got_log[0][15:8]}, 32'h0000_00F0);

    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
